// File: rtl/ps2_scancode_rx_pkg.sv
// PS/2 scancode receiver shared definitions.
// Prefix byte codes, frame length and receiver FSM states.
package bbc_ps2_pkg;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_t;

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Key event handshake between the PS/2 receiver and its consumer.
// The receiver side is master, the matrix logic is slave.
interface ps2_scancode_rx_if;

  logic       KEY_VALID;
  logic [7:0] KEY_CODE;
  logic       KEY_RELEASE;
  logic       KEY_EXT;
  logic       KEY_ACK;
  logic       FRAME_ERR;
  logic       OVERRUN;

  modport master (
    output KEY_VALID,
    output KEY_CODE,
    output KEY_RELEASE,
    output KEY_EXT,
    output FRAME_ERR,
    output OVERRUN,
    input  KEY_ACK
  );

  modport slave (
    input  KEY_VALID,
    input  KEY_CODE,
    input  KEY_RELEASE,
    input  KEY_EXT,
    input  FRAME_ERR,
    input  OVERRUN,
    output KEY_ACK
  );

endinterface

// File: rtl/ps2_scancode_rx_sync_edge.sv
// Two-flop synchronisers for the PS/2 pins plus falling-edge detect.
// Lines reset high (bus idle) so reset never fakes a clock edge.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data
);

  logic [2:0] clk_q;
  logic [1:0] dat_q;

  // Synchronise both lines; clk_q[2] is the previous synced clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_q <= 3'b111;
      dat_q <= 2'b11;
    end else begin
      clk_q <= {clk_q[1:0], ps2_clk};
      dat_q <= {dat_q[0], ps2_data};
    end
  end

  assign fall = clk_q[2] & ~clk_q[1];
  assign data = dat_q[1];

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 host receiver: frames bits into bytes, folds E0/F0 prefixes
// into key events and hands them out over a valid/ack register.
module ps2_scancode_rx
  import bbc_ps2_pkg::*;
#(
  parameter int TIMEOUT = 4000
) (
  input  logic CLK_hPROC,
  input  logic RESET,
  input  logic PS2_CLK,
  input  logic PS2_DATA,
  ps2_scancode_rx_if.master key
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state;
  state_t        state_nx;
  logic          fall;
  logic          bit_in;
  logic [10:0]   sr;
  logic [3:0]    cnt;
  logic [TW-1:0] timer;
  logic          rel_f;
  logic          ext_f;
  logic [7:0]    byte_v;
  logic          frame_ok;
  logic          to_hit;
  logic          emit;
  logic          chk_err;
  logic          to_err;

  ps2_sync_edge u_sync (
    .clk      (CLK_hPROC),
    .rst      (RESET),
    .ps2_clk  (PS2_CLK),
    .ps2_data (PS2_DATA),
    .fall     (fall),
    .data     (bit_in)
  );

  // sr[0] start, sr[8:1] data LSB first, sr[9] parity, sr[10] stop.
  assign byte_v   = sr[8:1];
  assign frame_ok = ~sr[0] & sr[10] & (^sr[9:1]);
  assign to_hit   = ~fall & (timer == TW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge CLK_hPROC) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (fall && !bit_in) state_nx = SHIFT;
      end
      SHIFT: begin
        if (fall && cnt == 4'(PS2_FRAME_BITS - 1))
          state_nx = CHECK;
        else if (to_hit)
          state_nx = IDLE;
      end
      CHECK:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM decode outputs: event emit and the two error sources.
  always_comb begin
    emit    = 1'b0;
    chk_err = 1'b0;
    to_err  = 1'b0;
    case (state)
      SHIFT: to_err = to_hit;
      CHECK: begin
        chk_err = ~frame_ok;
        emit    = frame_ok & (byte_v != PS2_EXT)
                & (byte_v != PS2_BREAK);
      end
      default: ;
    endcase
  end

  // Shift register, bit counter and inter-edge timeout counter.
  always_ff @(posedge CLK_hPROC) begin
    if (RESET) begin
      sr    <= '0;
      cnt   <= '0;
      timer <= '0;
    end else begin
      if (fall && (state == SHIFT || (state == IDLE && !bit_in)))
        sr <= {bit_in, sr[10:1]};
      if (state == IDLE && fall && !bit_in)
        cnt <= 4'd1;
      else if (state == SHIFT && fall)
        cnt <= cnt + 4'd1;
      if (state != SHIFT || fall)
        timer <= '0;
      else
        timer <= timer + TW'(1);
    end
  end

  // Prefix flags collected across E0/F0 bytes.
  always_ff @(posedge CLK_hPROC) begin
    if (RESET) begin
      rel_f <= 1'b0;
      ext_f <= 1'b0;
    end else if (state == CHECK) begin
      if (!frame_ok) begin
        rel_f <= 1'b0;
        ext_f <= 1'b0;
      end else begin
        unique case (1'b1)
          (byte_v == PS2_EXT):   ext_f <= 1'b1;
          (byte_v == PS2_BREAK): rel_f <= 1'b1;
          default: begin
            rel_f <= 1'b0;
            ext_f <= 1'b0;
          end
        endcase
      end
    end
  end

  // Output event register, error pulse and sticky overrun.
  always_ff @(posedge CLK_hPROC) begin
    if (RESET) begin
      key.KEY_VALID   <= 1'b0;
      key.KEY_CODE    <= 8'h00;
      key.KEY_RELEASE <= 1'b0;
      key.KEY_EXT     <= 1'b0;
      key.FRAME_ERR   <= 1'b0;
      key.OVERRUN     <= 1'b0;
    end else begin
      key.FRAME_ERR <= chk_err | to_err;
      if (emit) begin
        if (!key.KEY_VALID || key.KEY_ACK) begin
          key.KEY_VALID   <= 1'b1;
          key.KEY_CODE    <= byte_v;
          key.KEY_RELEASE <= rel_f;
          key.KEY_EXT     <= ext_f;
        end else begin
          key.OVERRUN <= 1'b1;
        end
      end else if (key.KEY_ACK) begin
        key.KEY_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx.
// Drives PS/2 frames on the pins and checks events with assertions.
module tb_ps2_scancode_rx;

  localparam int TO   = 4000;
  localparam int HALF = 5;

  logic clk = 1'b0;
  logic rst;
  logic ps2_clk;
  logic ps2_data;
  int   tests = 0;
  int   fails = 0;
  int   err_cycles = 0;
  logic lat3;
  logic lat4;

  ps2_scancode_rx_if kif ();

  ps2_scancode_rx #(.TIMEOUT(TO)) dut (
    .CLK_hPROC (clk),
    .RESET     (rst),
    .PS2_CLK   (ps2_clk),
    .PS2_DATA  (ps2_data),
    .key       (kif)
  );

  always #5 clk = ~clk;

  // Cycles with FRAME_ERR high (equals pulse count for 1-cycle pulses).
  always @(negedge clk) begin
    if (kif.FRAME_ERR === 1'b1) err_cycles = err_cycles + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] b,
                                          input logic bad);
    logic par;
    par = bad ? 1'b0 : ~(^b);
    return {1'b1, par, b, 1'b0};
  endfunction

  // Send the first n bits of a frame; records KEY_VALID 3 and 4
  // cycles after the stop-bit falling edge.
  task automatic ps2_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) begin
        repeat (3) @(negedge clk);
        lat3 = kif.KEY_VALID;
        @(negedge clk);
        lat4 = kif.KEY_VALID;
        repeat (HALF - 4) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    ps2_bits(mkframe(b, 1'b0), 11);
  endtask

  task automatic ack();
    @(negedge clk);
    kif.KEY_ACK = 1'b1;
    @(negedge clk);
    kif.KEY_ACK = 1'b0;
  endtask

  initial begin
    int bad;
    int e0;
    rst         = 1'b1;
    ps2_clk     = 1'b1;
    ps2_data    = 1'b1;
    kif.KEY_ACK = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_valid", 32'(kif.KEY_VALID), 0);
    chk("rst_code", 32'(kif.KEY_CODE), 0);
    chk("rst_ovr", 32'(kif.OVERRUN), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    send(8'h4D);
    chk("lat_3cyc", 32'(lat3), 0);
    chk("lat_4cyc", 32'(lat4), 1);
    chk("make_valid", 32'(kif.KEY_VALID), 1);
    chk("make_code", 32'(kif.KEY_CODE), 32'h4D);
    chk("make_rel", 32'(kif.KEY_RELEASE), 0);
    chk("make_ext", 32'(kif.KEY_EXT), 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (kif.KEY_VALID !== 1'b1 || kif.KEY_CODE !== 8'h4D)
        bad++;
    end
    chk("make_hold", 32'(bad), 0);
    ack();
    chk("ack_clear", 32'(kif.KEY_VALID), 0);

    send(8'hF0);
    chk("f0_no_event", 32'(kif.KEY_VALID), 0);
    send(8'h2D);
    chk("brk_valid", 32'(kif.KEY_VALID), 1);
    chk("brk_code", 32'(kif.KEY_CODE), 32'h2D);
    chk("brk_rel", 32'(kif.KEY_RELEASE), 1);
    chk("brk_ext", 32'(kif.KEY_EXT), 0);
    ack();

    send(8'hE0);
    chk("e0_no_event", 32'(kif.KEY_VALID), 0);
    send(8'hF0);
    chk("e0f0_no_event", 32'(kif.KEY_VALID), 0);
    send(8'h75);
    chk("xbrk_code", 32'(kif.KEY_CODE), 32'h75);
    chk("xbrk_ext", 32'(kif.KEY_EXT), 1);
    chk("xbrk_rel", 32'(kif.KEY_RELEASE), 1);
    ack();
    send(8'h75);
    chk("plain_valid", 32'(kif.KEY_VALID), 1);
    chk("plain_ext", 32'(kif.KEY_EXT), 0);
    chk("plain_rel", 32'(kif.KEY_RELEASE), 0);
    ack();

    e0 = err_cycles;
    ps2_bits(mkframe(8'h4D, 1'b1), 11);
    repeat (5) @(negedge clk);
    chk("par_err_cycles", 32'(err_cycles - e0), 1);
    chk("par_no_valid", 32'(kif.KEY_VALID), 0);
    send(8'h43);
    chk("par_next_code", 32'(kif.KEY_CODE), 32'h43);
    chk("par_next_valid", 32'(kif.KEY_VALID), 1);
    ack();

    e0 = err_cycles;
    ps2_bits(mkframe(8'h31, 1'b0), 5);
    chk("to_not_early", 32'(err_cycles - e0), 0);
    repeat (TO + 10) @(negedge clk);
    chk("to_err_cycles", 32'(err_cycles - e0), 1);
    chk("to_no_valid", 32'(kif.KEY_VALID), 0);
    send(8'h31);
    chk("to_next_code", 32'(kif.KEY_CODE), 32'h31);
    ack();

    send(8'h29);
    chk("ovr_before", 32'(kif.OVERRUN), 0);
    send(8'h3D);
    chk("ovr_code", 32'(kif.KEY_CODE), 32'h29);
    chk("ovr_valid", 32'(kif.KEY_VALID), 1);
    chk("ovr_flag", 32'(kif.OVERRUN), 1);

    ps2_bits(mkframe(8'h55, 1'b0), 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_valid", 32'(kif.KEY_VALID), 0);
    chk("mrst_code", 32'(kif.KEY_CODE), 0);
    chk("mrst_ovr", 32'(kif.OVERRUN), 0);
    chk("mrst_err", 32'(kif.FRAME_ERR), 0);
    repeat (4) @(negedge clk);
    send(8'h4E);
    chk("mrst_next_code", 32'(kif.KEY_CODE), 32'h4E);
    chk("mrst_next_rel", 32'(kif.KEY_RELEASE), 0);
    chk("mrst_next_ext", 32'(kif.KEY_EXT), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
